// File: rtl/pair_check_pkg.sv
// pair_check_pkg
// Shared encodings and constants for the count pair checker.
//   state_e : FSM state encodings (IDLE, TRACK, ERROR)
//   step_e  : step classification codes reported on step_kind
//   A_CARRY_VAL, STEP_BIG, STEP_SMALL : classification constants
package pair_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRACK = 2'b01,
    ST_ERROR = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    STEP_HOLD    = 2'b00,
    STEP_PLUS1   = 2'b01,
    STEP_PLUS3   = 2'b10,
    STEP_ILLEGAL = 2'b11
  } step_e;

  // A value from which B is allowed to advance by one (A carries into B).
  localparam logic [3:0] A_CARRY_VAL = 4'd7;
  localparam logic [3:0] STEP_BIG    = 4'd3;
  localparam logic [3:0] STEP_SMALL  = 4'd1;

endpackage

// File: rtl/nibble_delta_classify.sv
// nibble_delta_classify
// Combinational delta computation and step classification for a pair of
// producer words {B[7:4], A[3:0]}. Deltas are modulo 16, so wrap is legal.
// Ports:
//   prev_word  in  8  previous (baseline) word
//   cur_word   in  8  current word
//   delta_a    out 4  (A_cur - A_prev) mod 16
//   delta_b    out 4  (B_cur - B_prev) mod 16
//   step_kind  out 2  hold / plus1 / plus3 / illegal
module nibble_delta_classify
  import pair_check_pkg::*;
(
  input  logic [7:0] prev_word,
  input  logic [7:0] cur_word,
  output logic [3:0] delta_a,
  output logic [3:0] delta_b,
  output step_e      step_kind
);

  assign delta_a = cur_word[3:0] - prev_word[3:0];
  assign delta_b = cur_word[7:4] - prev_word[7:4];

  always_comb begin
    step_kind = STEP_ILLEGAL;
    if (delta_a != STEP_SMALL) begin
      step_kind = STEP_ILLEGAL;
    end else if (delta_b == 4'd0) begin
      step_kind = STEP_HOLD;
    end else if (delta_b == STEP_BIG) begin
      step_kind = STEP_PLUS3;
    end else if (delta_b == STEP_SMALL && prev_word[3:0] == A_CARRY_VAL) begin
      // B may only tick by one when A is leaving its carry value.
      step_kind = STEP_PLUS1;
    end else begin
      step_kind = STEP_ILLEGAL;
    end
  end

endmodule

// File: rtl/count_pair_checker.sv
// count_pair_checker
// Tracks successive producer words {B, A}, reports per-step deltas and a
// classification one cycle after each tracked word, and counts illegal
// steps (and optionally plus3 steps) with saturating counters.
// Optional feature macro: PAIR_CHECK_PLUS3_CNT_EN enables the plus3 counter;
// without it plus3_count is tied to zero.
// Ports:
//   clk          in   1      clock
//   clear        in   1      async active-high reset
//   in_valid     in   1      qualifies cct_word
//   cct_word     in   8      producer word {B[7:4], A[3:0]}
//   resync       in   1      drop history, back to IDLE (wins over in_valid)
//   out_valid    out  1      one-cycle result strobe
//   delta_a      out  4      A delta
//   delta_b      out  4      B delta
//   step_kind    out  2      step classification
//   state        out  2      FSM state
//   err          out  1      sticky illegal-step flag
//   err_count    out  CNT_W  saturating illegal-step count
//   plus3_count  out  CNT_W  saturating plus3-step count
//
// state  | meaning
// IDLE   | no baseline; next valid word becomes prev
// TRACK  | classifying steps, no illegal step seen
// ERROR  | illegal step seen; still classifying and counting
module count_pair_checker
  import pair_check_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [7:0]       cct_word,
  input  logic             resync,
  output logic             out_valid,
  output logic [3:0]       delta_a,
  output logic [3:0]       delta_b,
  output logic [1:0]       step_kind,
  output logic [1:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] plus3_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [7:0]       prev_q;
  logic             out_valid_q;
  logic [3:0]       delta_a_q;
  logic [3:0]       delta_b_q;
  logic [1:0]       step_kind_q;
  logic             err_q;
  logic [CNT_W-1:0] err_count_q;
`ifdef PAIR_CHECK_PLUS3_CNT_EN
  logic [CNT_W-1:0] plus3_count_q;
`endif

  logic [3:0] delta_a_d;
  logic [3:0] delta_b_d;
  step_e      step_kind_d;

  nibble_delta_classify u_classify (
    .prev_word (prev_q),
    .cur_word  (cct_word),
    .delta_a   (delta_a_d),
    .delta_b   (delta_b_d),
    .step_kind (step_kind_d)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q       <= ST_IDLE;
      prev_q        <= 8'h00;
      out_valid_q   <= 1'b0;
      delta_a_q     <= 4'h0;
      delta_b_q     <= 4'h0;
      step_kind_q   <= 2'b00;
      err_q         <= 1'b0;
      err_count_q   <= '0;
`ifdef PAIR_CHECK_PLUS3_CNT_EN
      plus3_count_q <= '0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      if (resync) begin
        // Sample discarded; counters deliberately keep their totals.
        state_q <= ST_IDLE;
        err_q   <= 1'b0;
      end else if (in_valid) begin
        case (state_q)
          ST_IDLE: begin
            prev_q  <= cct_word;
            state_q <= ST_TRACK;
          end
          ST_TRACK, ST_ERROR: begin
            prev_q      <= cct_word;
            out_valid_q <= 1'b1;
            delta_a_q   <= delta_a_d;
            delta_b_q   <= delta_b_d;
            step_kind_q <= step_kind_d;
            if (step_kind_d == STEP_ILLEGAL) begin
              err_q   <= 1'b1;
              state_q <= ST_ERROR;
              if (err_count_q != '1) begin
                err_count_q <= err_count_q + CNT_ONE;
              end
            end
`ifdef PAIR_CHECK_PLUS3_CNT_EN
            if (step_kind_d == STEP_PLUS3 && plus3_count_q != '1) begin
              plus3_count_q <= plus3_count_q + CNT_ONE;
            end
`endif
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign delta_a   = delta_a_q;
  assign delta_b   = delta_b_q;
  assign step_kind = step_kind_q;
  assign state     = state_q;
  assign err       = err_q;
  assign err_count = err_count_q;
`ifdef PAIR_CHECK_PLUS3_CNT_EN
  assign plus3_count = plus3_count_q;
`else
  assign plus3_count = '0;
`endif

endmodule

// File: tb/tb_count_pair_checker.sv
// Testbench for count_pair_checker: directed words, expected strobes pushed
// into a scoreboard queue, popped and compared by an independent monitor.
module tb_count_pair_checker;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             clear;
  logic             in_valid;
  logic [7:0]       cct_word;
  logic             resync;
  logic             out_valid;
  logic [3:0]       delta_a;
  logic [3:0]       delta_b;
  logic [1:0]       step_kind;
  logic [1:0]       state;
  logic             err;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] plus3_count;

  int checks   = 0;
  int failures = 0;

  // expected {delta_a, delta_b, step_kind}
  logic [9:0] exp_q[$];

  count_pair_checker #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .clear       (clear),
    .in_valid    (in_valid),
    .cct_word    (cct_word),
    .resync      (resync),
    .out_valid   (out_valid),
    .delta_a     (delta_a),
    .delta_b     (delta_b),
    .step_kind   (step_kind),
    .state       (state),
    .err         (err),
    .err_count   (err_count),
    .plus3_count (plus3_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe: got da=%0d db=%0d kind=%0d expected no strobe",
                 delta_a, delta_b, step_kind);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({delta_a, delta_b, step_kind} !== e) begin
          failures++;
          $display("FAIL strobe: got da=%0d db=%0d kind=%0d expected da=%0d db=%0d kind=%0d",
                   delta_a, delta_b, step_kind, e[9:6], e[5:2], e[1:0]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] w, input bit strobe,
                      input logic [3:0] da, input logic [3:0] db, input logic [1:0] kind);
    @(negedge clk);
    in_valid = 1'b1;
    cct_word = w;
    if (strobe) exp_q.push_back({da, db, kind});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      resync   = 1'b0;
    end
    #1;
  endtask

  task automatic do_clear();
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b1;
    #2;
    clear = 1'b0;
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 0);
  endtask

  int plus3_exp;

  initial begin
    clear    = 1'b1;
    in_valid = 1'b0;
    cct_word = 8'h00;
    resync   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {delta_a, delta_b, step_kind}, 0);
    check("rst_err", err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_plus3", plus3_count, 0);
    @(negedge clk);
    clear = 1'b0;

    // plus3 chain
    send(8'h00, 0, 0, 0, 0);
    send(8'h31, 1, 4'd1, 4'd3, 2'b10);
    send(8'h62, 1, 4'd1, 4'd3, 2'b10);
    idle(3);
`ifdef PAIR_CHECK_PLUS3_CNT_EN
    plus3_exp = 2;
`else
    plus3_exp = 0;
`endif
    check("s1_state", state, 1);
    check("s1_err", err, 0);
    check("s1_plus3", plus3_count, plus3_exp);
    check_drained("s1_drained");

    // plus1 from carry value
    do_clear();
    send(8'h07, 0, 0, 0, 0);
    send(8'h18, 1, 4'd1, 4'd1, 2'b01);
    idle(3);
    check("s2a_err", err, 0);
    check("s2a_state", state, 1);

    // B+1 without carry is illegal
    do_clear();
    send(8'h05, 0, 0, 0, 0);
    send(8'h16, 1, 4'd1, 4'd1, 2'b11);
    idle(3);
    check("s2b_err", err, 1);
    check("s2b_err_count", err_count, 1);
    check("s2b_state", state, 2);
    check_drained("s2_drained");

    // hold, resync, then wrap-around plus3
    do_clear();
    send(8'h24, 0, 0, 0, 0);
    send(8'h25, 1, 4'd1, 4'd0, 2'b00);
    idle(2);
    @(negedge clk);
    resync = 1'b1;
    idle(2);
    check("s3_resync_state", state, 0);
    send(8'hDF, 0, 0, 0, 0);
    send(8'h00, 1, 4'd1, 4'd3, 2'b10);
    idle(3);
    check("s3_err", err, 0);
    check("s3_state", state, 1);
`ifdef PAIR_CHECK_PLUS3_CNT_EN
    plus3_exp = 1;
`else
    plus3_exp = 0;
`endif
    check("s3_plus3", plus3_count, plus3_exp);
    check_drained("s3_drained");

    // saturation of err_count, then resync with in_valid
    do_clear();
    send(8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) send(8'h00, 1, 4'd0, 4'd0, 2'b11);
    idle(3);
    check("s4_err_count_sat", err_count, 255);
    check("s4_err", err, 1);
    check("s4_state", state, 2);
    @(negedge clk);
    in_valid = 1'b1;
    cct_word = 8'h01;
    resync   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    resync   = 1'b0;
    #1;
    check("s4_resync_out_valid", out_valid, 0);
    check("s4_resync_state", state, 0);
    check("s4_resync_err", err, 0);
    check("s4_resync_err_count", err_count, 255);
    idle(2);
    check_drained("s4_drained");

    // async clear with a strobe pending
    do_clear();
    send(8'h10, 0, 0, 0, 0);
    send(8'h21, 0, 0, 0, 0);  // its strobe is killed by clear below
    @(posedge clk);
    #2;
    clear = 1'b1;
    #1;
    check("s5_clr_out_valid", out_valid, 0);
    check("s5_clr_state", state, 0);
    check("s5_clr_outputs", {delta_a, delta_b, step_kind}, 0);
    check("s5_clr_counts", {err, err_count, plus3_count}, 0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    send(8'h42, 0, 0, 0, 0);
    idle(3);
    check("s5_state", state, 1);
    check_drained("s5_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
